// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // Sequencer states, fixed 3-bit encoding so the debug port is stable.
  typedef enum logic [2:0] {
    PCTL_IDLE     = 3'd0,
    PCTL_RUN      = 3'd1,
    PCTL_MEM_WAIT = 3'd2,
    PCTL_FLUSH    = 3'd3,
    PCTL_HALTED   = 3'd4
  } pctl_state_e;

  localparam int PCTL_FLUSH_CYCLES_DEFAULT = 2;
  localparam int PCTL_FCNT_W               = 3;

  // Pipeline control bundle, one bit per control line.
  typedef struct packed {
    logic pc_en;
    logic pc_sel_branch;
    logic if_id_en;
    logic if_id_flush;
    logic id_exe_en;
    logic id_exe_flush;
    logic exe_mem_en;
    logic mem_wb_en;
  } pctl_ctrl_t;

  // Everything frozen.
  localparam pctl_ctrl_t CTRL_NONE   = 8'b0000_0000;
  // Normal advance of every stage.
  localparam pctl_ctrl_t CTRL_ALL    = 8'b1010_1011;
  // Taken branch: redirect PC, squash the two younger stages.
  localparam pctl_ctrl_t CTRL_BRANCH = 8'b1111_1111;
  // Hold IF/ID and PC, push a bubble into EXE, drain the rest.
  localparam pctl_ctrl_t CTRL_BUBBLE = 8'b0000_1111;
  // Post-branch squash cycles: sequential fetch, younger stages flushed.
  localparam pctl_ctrl_t CTRL_FLUSH  = 8'b1011_1111;

  function automatic logic pctl_is_running(input pctl_state_e s);
    return (s == PCTL_RUN) || (s == PCTL_MEM_WAIT) || (s == PCTL_FLUSH);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request and control bundle between the pipeline and its sequencer.
// Requests are level signals sampled every cycle (start and
// branch_taken_EXE are one-cycle pulses); controls are combinational
// from the sequencer state and the current requests, no handshake.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipeline_ctrl_pkg::*;

  logic             start;
  logic             halt_ID;
  logic             hazard_detected;
  logic             branch_taken_EXE;
  logic             mem_busy;

  logic             pc_en;
  logic             pc_sel_branch;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_exe_en;
  logic             id_exe_flush;
  logic             exe_mem_en;
  logic             mem_wb_en;
  logic             running;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Sequencer side.
  modport master (
    input  start, halt_ID, hazard_detected, branch_taken_EXE, mem_busy,
    output pc_en, pc_sel_branch, if_id_en, if_id_flush, id_exe_en,
           id_exe_flush, exe_mem_en, mem_wb_en, running, stall_cnt, flush_cnt
  );

  // Pipeline side.
  modport slave (
    output start, halt_ID, hazard_detected, branch_taken_EXE, mem_busy,
    input  pc_en, pc_sel_branch, if_id_en, if_id_flush, id_exe_en,
           id_exe_flush, exe_mem_en, mem_wb_en, running, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = PCTL_FLUSH_CYCLES_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipeline_ctrl_if.master bus,
  output pctl_state_e state_dbg
);

  // The branch cycle itself is the first squash cycle, so FLUSH lasts
  // FLUSH_CYCLES-1 cycles.
  localparam logic [PCTL_FCNT_W-1:0] FLUSH_LOAD = PCTL_FCNT_W'(FLUSH_CYCLES - 1);

  pctl_state_e             state, state_nxt;
  logic [PCTL_FCNT_W-1:0]  fcnt, fcnt_nxt;
  pctl_ctrl_t              ctrl;
  logic                    running;
  logic                    stall_inc;
  logic                    flush_inc;

  // State and squash-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PCTL_IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next-state and control decode. MEM_WAIT shares the RUN decode: while
  // memory is busy it re-enters MEM_WAIT, and on release the RUN rules
  // apply in the same cycle.
  always_comb begin
    ctrl      = CTRL_NONE;
    state_nxt = state;
    fcnt_nxt  = fcnt;
    flush_inc = 1'b0;
    case (state)
      PCTL_IDLE, PCTL_HALTED: begin
        if (bus.start) state_nxt = PCTL_RUN;
      end
      PCTL_RUN, PCTL_MEM_WAIT: begin
        if (bus.mem_busy) begin
          // EXE is frozen, so a coincident branch is re-presented later.
          state_nxt = PCTL_MEM_WAIT;
        end else if (bus.branch_taken_EXE) begin
          ctrl      = CTRL_BRANCH;
          fcnt_nxt  = FLUSH_LOAD;
          flush_inc = 1'b1;
          state_nxt = (FLUSH_CYCLES > 1) ? PCTL_FLUSH : PCTL_RUN;
        end else if (bus.halt_ID) begin
          // Halt is replaced by a bubble so it never reaches EXE.
          ctrl      = CTRL_BUBBLE;
          state_nxt = PCTL_HALTED;
        end else if (bus.hazard_detected) begin
          ctrl      = CTRL_BUBBLE;
          state_nxt = PCTL_RUN;
        end else begin
          ctrl      = CTRL_ALL;
          state_nxt = PCTL_RUN;
        end
      end
      PCTL_FLUSH: begin
        // Hazards and halts come from squashed instructions; ignore them.
        if (!bus.mem_busy) begin
          ctrl     = CTRL_FLUSH;
          fcnt_nxt = (fcnt != '0) ? fcnt - 1'b1 : '0;
          if (fcnt <= 1) state_nxt = PCTL_RUN;
        end
      end
      default: begin
        state_nxt = PCTL_IDLE;
      end
    endcase
  end

  // Performance event qualification.
  always_comb begin
    running   = pctl_is_running(state);
    stall_inc = running & ~ctrl.pc_en;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (bus.flush_cnt)
  );

  assign bus.pc_en         = ctrl.pc_en;
  assign bus.pc_sel_branch = ctrl.pc_sel_branch;
  assign bus.if_id_en      = ctrl.if_id_en;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_exe_en     = ctrl.id_exe_en;
  assign bus.id_exe_flush  = ctrl.id_exe_flush;
  assign bus.exe_mem_en    = ctrl.exe_mem_en;
  assign bus.mem_wb_en     = ctrl.mem_wb_en;
  assign bus.running       = running;
  assign state_dbg         = state;

endmodule
